// File: rtl/fir_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_pkg : shared FIR state encoding and width/saturation helpers. Rev 1.0
// ---------------------------------------------------------------------------
package fir_pkg;

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Product width plus enough guard bits to sum every tap without overflow
   function automatic int acc_width(input int bw_in, input int n_taps);
      return 2 * bw_in + $clog2(n_taps);
   endfunction

   function automatic longint sat_max(input int bw);
      return (longint'(1) <<< (bw - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int bw);
      return -(longint'(1) <<< (bw - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_sat : arithmetic right shift then saturate or wrap to BW_OUT. Rev 1.0
// ---------------------------------------------------------------------------
module fir_sat
   import fir_pkg::*;
#(
   parameter int IN_W   = 14,
   parameter int BW_OUT = 8,
   parameter int SHIFT  = 0,
   parameter int SAT    = 1
) (
   input  logic signed [IN_W-1:0]   sum,
   output logic signed [BW_OUT-1:0] result
);

   logic signed [IN_W-1:0] w_shifted;

   assign w_shifted = sum >>> SHIFT;

   generate
      if (SAT != 0) begin : g_sat
         localparam longint c_MAX = sat_max(BW_OUT);
         localparam longint c_MIN = sat_min(BW_OUT);

         always_comb begin
            result = BW_OUT'(w_shifted);
            if (longint'(w_shifted) > c_MAX) begin
               result = BW_OUT'(c_MAX);
            end else if (longint'(w_shifted) < c_MIN) begin
               result = BW_OUT'(c_MIN);
            end
         end
      end else begin : g_wrap
         // Signed size cast keeps the low bits (or sign-extends a narrow sum)
         assign result = BW_OUT'(w_shifted);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_stream : streaming FIR with serial coefficient load and 2-stage output. Rev 1.0
// ---------------------------------------------------------------------------
module fir_stream
   import fir_pkg::*;
#(
   parameter int N_TAPS = 4,
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 8,
   parameter int SHIFT  = 0,
   parameter int SAT    = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_req,
   input  logic                     in_valid,
   input  logic signed [BW_IN-1:0]  in_data,
   output logic                     coef_loaded,
   output logic                     out_valid,
   output logic signed [BW_OUT-1:0] out_data
);

   localparam int c_PROD_W = 2 * BW_IN;
   localparam int c_ACC_W  = acc_width(BW_IN, N_TAPS);
   localparam int c_CNT_W  = $clog2(N_TAPS);

   state_t                    r_state, w_state_next;
   logic [c_CNT_W-1:0]        r_cnt;
   logic signed [BW_IN-1:0]   r_coef [N_TAPS];
   logic signed [BW_IN-1:0]   r_samp [N_TAPS];
   logic signed [c_PROD_W-1:0] r_prod [N_TAPS];
   logic                      r_samp_v, r_prod_v, r_out_v;
   logic signed [BW_OUT-1:0]  r_out;
   logic signed [c_ACC_W-1:0] w_sum;
   logic signed [BW_OUT-1:0]  w_sat;
   logic                      w_coef_we, w_samp_we, w_last_coef;

   // load_req wins over in_valid, so the coincident data word is dropped
   assign w_coef_we   = (r_state == LOAD) && in_valid && !load_req;
   assign w_samp_we   = (r_state == RUN)  && in_valid && !load_req;
   assign w_last_coef = w_coef_we && (r_cnt == c_CNT_W'(N_TAPS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         LOAD:    if (w_last_coef) w_state_next = RUN;
         RUN:     if (load_req)    w_state_next = LOAD;
         default: w_state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         for (int k = 0; k < N_TAPS; k++) begin
            r_coef[k] <= '0;
            r_samp[k] <= '0;
         end
      end else if (load_req) begin
         r_cnt <= '0;
         for (int k = 0; k < N_TAPS; k++) begin
            r_samp[k] <= '0;
         end
      end else if (w_coef_we) begin
         r_cnt     <= w_last_coef ? '0 : r_cnt + 1'b1;
         r_coef[0] <= in_data;
         for (int k = 1; k < N_TAPS; k++) begin
            r_coef[k] <= r_coef[k-1];
         end
      end else if (w_samp_we) begin
         r_samp[0] <= in_data;
         for (int k = 1; k < N_TAPS; k++) begin
            r_samp[k] <= r_samp[k-1];
         end
      end
   end

   generate
      for (genvar k = 0; k < N_TAPS; k++) begin : g_prod
         always_ff @(posedge clk) begin
            r_prod[k] <= c_PROD_W'(r_coef[k]) * c_PROD_W'(r_samp[k]);
         end
      end
   endgenerate

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         w_sum = w_sum + c_ACC_W'(r_prod[k]);
      end
   end

   fir_sat #(
      .IN_W   (c_ACC_W),
      .BW_OUT (BW_OUT),
      .SHIFT  (SHIFT),
      .SAT    (SAT)
   ) u_sat (
      .sum    (w_sum),
      .result (w_sat)
   );

   // Valid pipeline; a reload request kills anything still in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         r_samp_v <= 1'b0;
         r_prod_v <= 1'b0;
         r_out_v  <= 1'b0;
         r_out    <= '0;
      end else begin
         r_samp_v <= w_samp_we;
         r_prod_v <= r_samp_v && !load_req;
         r_out_v  <= r_prod_v && !load_req;
         if (r_prod_v && !load_req) begin
            r_out <= w_sat;
         end
      end
   end

   assign coef_loaded = (r_state == RUN);
   assign out_valid   = r_out_v;
   assign out_data    = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fir_stream : vector table, directed corners and random run vs. a model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fir_stream;

   localparam int N     = 4;
   localparam int SHIFT = 0;

   logic clk = 1'b0;
   logic reset, load_req, in_valid;
   logic signed [5:0] in_data;
   logic cl1, ov1, cl0, ov0;
   logic signed [7:0] od1, od0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fir_stream #(.N_TAPS(N), .BW_IN(6), .BW_OUT(8), .SHIFT(SHIFT), .SAT(1)) dut_sat (
      .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
      .in_data(in_data), .coef_loaded(cl1), .out_valid(ov1), .out_data(od1));

   fir_stream #(.N_TAPS(N), .BW_IN(6), .BW_OUT(8), .SHIFT(SHIFT), .SAT(0)) dut_wrap (
      .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
      .in_data(in_data), .coef_loaded(cl0), .out_valid(ov0), .out_data(od0));

   // Reference model: coefficient/sample lists plus timestamped pending results
   typedef struct { int due; int y; } pend_t;
   pend_t pend[$];
   int  mc[N];
   int  mx[N];
   int  mcnt;
   bit  mrun;
   int  held1, held0;
   int  cyc_n;

   typedef struct { bit lr; bit iv; int d; bit ev; int ed; bit el; } vec_t;
   vec_t tbl[18];

   function automatic int shape(input int y, input bit sat);
      int v;
      v = y >>> SHIFT;
      if (sat) begin
         if (v > 127)  return 127;
         if (v < -128) return -128;
         return v;
      end
      v = v & 255;
      if (v > 127) v = v - 256;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic tick(input bit r, input bit lr, input bit iv, input int d);
      int  y;
      bit  ev;
      reset    = r;
      load_req = lr;
      in_valid = iv;
      in_data  = 6'(d);
      @(posedge clk);
      cyc_n++;
      if (r) begin
         mrun = 0; mcnt = 0; held1 = 0; held0 = 0;
         for (int k = 0; k < N; k++) begin mc[k] = 0; mx[k] = 0; end
         pend.delete();
      end else if (lr) begin
         mrun = 0; mcnt = 0;
         for (int k = 0; k < N; k++) mx[k] = 0;
         pend.delete();
      end else if (iv && !mrun) begin
         for (int k = N - 1; k > 0; k--) mc[k] = mc[k-1];
         mc[0] = d;
         mcnt++;
         if (mcnt == N) begin mrun = 1; mcnt = 0; end
      end else if (iv) begin
         for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
         mx[0] = d;
         y = 0;
         for (int k = 0; k < N; k++) y += mc[k] * mx[k];
         pend.push_back('{cyc_n + 2, y});
      end
      #1;
      ev = 0;
      if (pend.size() > 0 && pend[0].due == cyc_n) begin
         ev    = 1;
         held1 = shape(pend[0].y, 1'b1);
         held0 = shape(pend[0].y, 1'b0);
         void'(pend.pop_front());
      end
      chk("coef_loaded",    cl1, int'(mrun));
      chk("coef_loaded_w",  cl0, int'(mrun));
      chk("out_valid",      ov1, int'(ev));
      chk("out_valid_w",    ov0, int'(ev));
      chk("out_data",       od1, held1);
      chk("out_data_w",     od0, held0);
   endtask

   initial begin
      reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0;
      mrun = 0; mcnt = 0; held1 = 0; held0 = 0; cyc_n = 0;

      // Coefficients 1..4, impulse, then a 1,0,1,1 valid pattern
      tbl[0]  = '{0, 1, 1, 0, 0, 0};
      tbl[1]  = '{0, 1, 2, 0, 0, 0};
      tbl[2]  = '{0, 1, 3, 0, 0, 0};
      tbl[3]  = '{0, 1, 4, 0, 0, 1};
      tbl[4]  = '{0, 1, 1, 0, 0, 1};
      tbl[5]  = '{0, 1, 0, 0, 0, 1};
      tbl[6]  = '{0, 1, 0, 1, 4, 1};
      tbl[7]  = '{0, 1, 0, 1, 3, 1};
      tbl[8]  = '{0, 1, 0, 1, 2, 1};
      tbl[9]  = '{0, 0, 0, 1, 1, 1};
      tbl[10] = '{0, 0, 0, 1, 0, 1};
      tbl[11] = '{0, 1, 2, 0, 0, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 1};
      tbl[13] = '{0, 1, 1, 1, 8, 1};
      tbl[14] = '{0, 1, 0, 0, 8, 1};
      tbl[15] = '{0, 0, 0, 1, 10, 1};
      tbl[16] = '{0, 0, 0, 1, 7, 1};
      tbl[17] = '{0, 0, 0, 0, 7, 1};

      tick(1, 0, 0, 0);
      tick(1, 1, 1, 5);
      chk("reset_loaded", cl1, 0);
      chk("reset_valid",  ov1, 0);
      chk("reset_data",   od1, 0);

      for (int i = 0; i < 18; i++) begin
         tick(0, tbl[i].lr, tbl[i].iv, tbl[i].d);
         chk($sformatf("vec%0d_valid", i),  ov1, int'(tbl[i].ev));
         chk($sformatf("vec%0d_data", i),   od1, tbl[i].ed);
         chk($sformatf("vec%0d_loaded", i), cl1, int'(tbl[i].el));
      end

      // Reload request mid-stream with a coincident sample
      tick(0, 0, 1, 5);
      tick(0, 0, 1, 5);
      tick(0, 1, 1, 7);
      chk("reload_loaded", cl1, 0);
      chk("reload_valid",  ov1, 0);
      chk("reload_hold",   od1, 7);
      tick(0, 0, 0, 0);
      chk("reload_inflight", ov1, 0);
      for (int i = 1; i <= 4; i++) tick(0, 0, 1, i);
      chk("reload_run", cl1, 1);
      tick(0, 0, 1, 1);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("reload_y_valid", ov1, 1);
      chk("reload_y_data",  od1, 4);

      // Saturation versus wrap at both extremes
      tick(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick(0, 0, 1, 31);
      for (int i = 0; i < 6; i++) tick(0, 0, 1, 31);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("sat_pos",  od1, 127);
      chk("wrap_pos", od0, 4);
      for (int i = 0; i < 6; i++) tick(0, 0, 1, -32);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("sat_neg",  od1, -128);
      chk("wrap_neg", od0, -128);

      // Reset part-way through a coefficient load
      tick(0, 1, 0, 0);
      tick(0, 0, 1, 3);
      tick(0, 0, 1, 3);
      tick(1, 0, 1, 3);
      chk("midload_rst_data",   od1, 0);
      chk("midload_rst_loaded", cl1, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, i + 1);
      chk("midload_3_words", cl1, 0);
      tick(0, 0, 1, 9);
      chk("midload_4_words", cl1, 1);

      // Random traffic including sporadic reloads and resets
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0, int'($urandom_range(0, 63)) - 32);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
